// File: rtl/lc3_mem_ctrl.sv
// lc3_mem_ctrl
// Memory-side access controller for the LC-3 datapath. It owns MAR and MDR.
// It sequences read/write accesses with MEM_LATENCY wait states and signals
// completion on R. It also decodes the xFE00-xFFFF I/O page into the keyboard
// (KBSR/KBDR) and display (DSR/DDR) device registers.
//
// Parameters:
//   MEM_LATENCY  wait-state cycles per access, legal range 1..15
// Ports:
//   clk, reset           system clock, synchronous active-high reset
//   Buss                 datapath bus (source for MAR and MDR loads)
//   ldMAR, ldMDR         register load strobes
//   selMDR               MDR source: 0 = Buss, 1 = read data
//   memEN, rW            start an access, 1 = write / 0 = read
//   memOut               asynchronous read data from the memory array
//   MARReg, mdrOut       array address and array write data
//   memWE                array write enable (one cycle, in DONE only)
//   R                    access-complete strobe (one cycle, in DONE only)
//   kbStrobe, kbChar     keyboard character available / character
//   dispChar, dispValid  display character and write strobe
//   dispAck              display has consumed a character

module lc3_mem_ctrl #(
    parameter int MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] Buss,
    input  logic        ldMAR,
    input  logic        ldMDR,
    input  logic        selMDR,
    input  logic        memEN,
    input  logic        rW,
    input  logic [15:0] memOut,
    output logic [15:0] MARReg,
    output logic [15:0] mdrOut,
    output logic        memWE,
    output logic        R,
    input  logic        kbStrobe,
    input  logic [7:0]  kbChar,
    output logic [7:0]  dispChar,
    output logic        dispValid,
    input  logic        dispAck
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [15:0] KBSR_ADDR = 16'hFE00;
    localparam logic [15:0] KBDR_ADDR = 16'hFE02;
    localparam logic [15:0] DSR_ADDR  = 16'hFE04;
    localparam logic [15:0] DDR_ADDR  = 16'hFE06;

    state_t      state;
    logic [3:0]  wait_cnt;
    logic        rw_lat;
    logic        kb_ready;
    logic [7:0]  kb_data;
    logic        disp_ready;

    logic        is_io;
    logic        mem_write;
    logic        ddr_write;
    logic [15:0] io_data;
    logic [15:0] read_data;

    assign is_io     = (MARReg[15:9] == 7'b1111111);
    assign mem_write = rw_lat && !is_io;
    assign ddr_write = rw_lat && (MARReg == DDR_ADDR);

    // I/O register read mux; DDR is write-only and unmapped I/O reads as zero.
    always_comb begin
        io_data = 16'h0000;
        case (MARReg)
            KBSR_ADDR: io_data = {kb_ready, 15'b0};
            KBDR_ADDR: io_data = {8'h00, kb_data};
            DSR_ADDR:  io_data = {disp_ready, 15'b0};
            default:   io_data = 16'h0000;
        endcase
    end

    assign read_data = is_io ? io_data : memOut;

    // Access FSM, MAR/MDR and device registers. memWE, R and dispValid are
    // set on the WAIT->DONE edge so they are high for exactly the DONE cycle.
    // The dispChar update happens on that same edge, so the character is
    // already valid while dispValid is high. The DSR clear and the KBSR clear
    // happen on the DONE->IDLE edge. That ordering lets a DDR write win over a
    // dispAck in the DONE cycle, and lets a kbStrobe win over a completing
    // KBDR read.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            wait_cnt   <= 4'd0;
            rw_lat     <= 1'b0;
            MARReg     <= 16'h0000;
            mdrOut     <= 16'h0000;
            memWE      <= 1'b0;
            R          <= 1'b0;
            kb_ready   <= 1'b0;
            kb_data    <= 8'h00;
            disp_ready <= 1'b1;
            dispChar   <= 8'h00;
            dispValid  <= 1'b0;
        end else begin
            memWE     <= 1'b0;
            R         <= 1'b0;
            dispValid <= 1'b0;

            // Address and write data stay frozen while an access is in flight.
            if (ldMAR && state == IDLE) begin
                MARReg <= Buss;
            end
            if (ldMDR) begin
                if (selMDR && state != WAIT) begin
                    mdrOut <= read_data;
                end else if (!selMDR && state == IDLE) begin
                    mdrOut <= Buss;
                end
            end

            if (kbStrobe) begin
                kb_data  <= kbChar;
                kb_ready <= 1'b1;
            end
            if (dispAck) begin
                disp_ready <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (memEN) begin
                        rw_lat   <= rW;
                        wait_cnt <= 4'(MEM_LATENCY - 1);
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state     <= DONE;
                        R         <= 1'b1;
                        memWE     <= mem_write;
                        dispValid <= ddr_write;
                        if (ddr_write) begin
                            dispChar <= mdrOut[7:0];
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    if (ddr_write) begin
                        disp_ready <= 1'b0;
                    end
                    if (!rw_lat && MARReg == KBDR_ADDR && !kbStrobe) begin
                        kb_ready <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// tb_lc3_mem_ctrl
// Directed self-checking bench for lc3_mem_ctrl with MEM_LATENCY = 2.
// A behavioural word-addressed memory array sits on MARReg/mdrOut/memWE/memOut.

module tb_lc3_mem_ctrl;

    localparam int LAT = 2;

    logic        clk;
    logic        reset;
    logic [15:0] Buss;
    logic        ldMAR;
    logic        ldMDR;
    logic        selMDR;
    logic        memEN;
    logic        rW;
    logic [15:0] memOut;
    logic [15:0] MARReg;
    logic [15:0] mdrOut;
    logic        memWE;
    logic        R;
    logic        kbStrobe;
    logic [7:0]  kbChar;
    logic [7:0]  dispChar;
    logic        dispValid;
    logic        dispAck;

    logic [15:0] mem [0:65535];

    int testsRun;
    int testsFailed;

    // Per-access observations gathered by applyStimulus.
    int          rCount;
    int          rCycle;
    int          weCount;
    int          weCycle;
    int          dvCount;
    logic [7:0]  dvChar;
    logic        injKb;
    logic [7:0]  injChar;
    logic        injAck;
    logic        stress;
    logic [15:0] rdata;

    lc3_mem_ctrl #(.MEM_LATENCY(LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .Buss      (Buss),
        .ldMAR     (ldMAR),
        .ldMDR     (ldMDR),
        .selMDR    (selMDR),
        .memEN     (memEN),
        .rW        (rW),
        .memOut    (memOut),
        .MARReg    (MARReg),
        .mdrOut    (mdrOut),
        .memWE     (memWE),
        .R         (R),
        .kbStrobe  (kbStrobe),
        .kbChar    (kbChar),
        .dispChar  (dispChar),
        .dispValid (dispValid),
        .dispAck   (dispAck)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory array model: asynchronous read, write on the clock edge.
    assign memOut = mem[MARReg];
    always @(posedge clk) begin
        if (memWE) mem[MARReg] <= mdrOut;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] actual,
                               input logic [15:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // One full access: load MAR, preload MDR (write data, or xDEAD for reads
    // so a missed capture is visible), pulse memEN for one cycle, then watch
    // a bounded window. For reads, MDR is captured in the DONE cycle.
    task automatic applyStimulus(input logic [15:0] addr, input logic wr,
                                 input logic [15:0] wdata, output logic [15:0] rd);
        rCount = 0; rCycle = -1; weCount = 0; weCycle = -1; dvCount = 0; dvChar = 8'h00;
        ldMAR = 1'b1; Buss = addr;
        tick;
        ldMAR = 1'b0; ldMDR = 1'b1; selMDR = 1'b0; Buss = wr ? wdata : 16'hDEAD;
        tick;
        ldMDR = 1'b0; Buss = 16'h0000; memEN = 1'b1; rW = wr;
        tick;
        memEN = 1'b0; rW = 1'b0;
        for (int c = 1; c <= LAT + 4; c++) begin
            if (R) begin rCount++; rCycle = c; end
            if (memWE) begin weCount++; weCycle = c; end
            if (dispValid) begin dvCount++; dvChar = dispChar; end
            ldMAR = 1'b0; ldMDR = 1'b0; selMDR = 1'b0; kbStrobe = 1'b0;
            dispAck = 1'b0; Buss = 16'h0000;
            if (R) begin
                if (!wr) begin ldMDR = 1'b1; selMDR = 1'b1; end
                if (injKb) begin kbStrobe = 1'b1; kbChar = injChar; end
                if (injAck) dispAck = 1'b1;
            end else if (stress && c <= LAT) begin
                ldMAR = 1'b1; ldMDR = 1'b1; selMDR = 1'b0; Buss = 16'h1234;
            end
            tick;
        end
        ldMAR = 1'b0; ldMDR = 1'b0; selMDR = 1'b0; kbStrobe = 1'b0;
        dispAck = 1'b0; Buss = 16'h0000;
        injKb = 1'b0; injAck = 1'b0; stress = 1'b0;
        rd = mdrOut;
    endtask

    initial begin
        testsRun = 0; testsFailed = 0;
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        Buss = 16'h0000; ldMAR = 1'b0; ldMDR = 1'b0; selMDR = 1'b0;
        memEN = 1'b0; rW = 1'b0; kbStrobe = 1'b0; kbChar = 8'h00; dispAck = 1'b0;
        injKb = 1'b0; injChar = 8'h00; injAck = 1'b0; stress = 1'b0;
        reset = 1'b1;
        tick;
        tick;
        reset = 1'b0;

        // Reset state
        checkOutput("rst MARReg", MARReg, 16'h0000);
        checkOutput("rst mdrOut", mdrOut, 16'h0000);
        checkOutput("rst memWE", {15'b0, memWE}, 16'h0000);
        checkOutput("rst R", {15'b0, R}, 16'h0000);
        checkOutput("rst dispChar", {8'h00, dispChar}, 16'h0000);
        checkOutput("rst dispValid", {15'b0, dispValid}, 16'h0000);
        applyStimulus(16'hFE04, 1'b0, 16'h0000, rdata);
        checkOutput("rst DSR", rdata, 16'h8000);
        applyStimulus(16'hFE00, 1'b0, 16'h0000, rdata);
        checkOutput("rst KBSR", rdata, 16'h0000);

        // Memory write/read
        applyStimulus(16'h0010, 1'b1, 16'hBEEF, rdata);
        checkOutput("wr R cycle", 16'(rCycle), 16'(LAT + 1));
        checkOutput("wr R count", 16'(rCount), 16'd1);
        checkOutput("wr memWE cycle", 16'(weCycle), 16'(LAT + 1));
        checkOutput("wr memWE count", 16'(weCount), 16'd1);
        checkOutput("wr mem[0010]", mem[16'h0010], 16'hBEEF);
        applyStimulus(16'h0011, 1'b1, 16'hA5A5, rdata);
        checkOutput("wr mem[0011]", mem[16'h0011], 16'hA5A5);
        applyStimulus(16'h0010, 1'b0, 16'h0000, rdata);
        checkOutput("rd 0010", rdata, 16'hBEEF);
        checkOutput("rd R cycle", 16'(rCycle), 16'(LAT + 1));
        checkOutput("rd memWE count", 16'(weCount), 16'd0);
        applyStimulus(16'h0011, 1'b0, 16'h0000, rdata);
        checkOutput("rd 0011", rdata, 16'hA5A5);

        // Keyboard
        kbChar = 8'h41; kbStrobe = 1'b1;
        tick;
        kbStrobe = 1'b0;
        applyStimulus(16'hFE00, 1'b0, 16'h0000, rdata);
        checkOutput("kb KBSR set", rdata, 16'h8000);
        applyStimulus(16'hFE02, 1'b0, 16'h0000, rdata);
        checkOutput("kb KBDR 41", rdata, 16'h0041);
        applyStimulus(16'hFE00, 1'b0, 16'h0000, rdata);
        checkOutput("kb KBSR cleared", rdata, 16'h0000);
        kbChar = 8'h41; kbStrobe = 1'b1;
        tick;
        kbStrobe = 1'b0;
        injKb = 1'b1; injChar = 8'h42;
        applyStimulus(16'hFE02, 1'b0, 16'h0000, rdata);
        checkOutput("kb race old char", rdata, 16'h0041);
        applyStimulus(16'hFE00, 1'b0, 16'h0000, rdata);
        checkOutput("kb race KBSR", rdata, 16'h8000);
        applyStimulus(16'hFE02, 1'b0, 16'h0000, rdata);
        checkOutput("kb race KBDR", rdata, 16'h0042);

        // Display
        applyStimulus(16'hFE06, 1'b1, 16'h0033, rdata);
        checkOutput("disp valid count", 16'(dvCount), 16'd1);
        checkOutput("disp char at valid", {8'h00, dvChar}, 16'h0033);
        checkOutput("disp dispChar", {8'h00, dispChar}, 16'h0033);
        checkOutput("disp memWE count", 16'(weCount), 16'd0);
        applyStimulus(16'hFE04, 1'b0, 16'h0000, rdata);
        checkOutput("disp DSR busy", rdata, 16'h0000);
        dispAck = 1'b1;
        tick;
        dispAck = 1'b0;
        applyStimulus(16'hFE04, 1'b0, 16'h0000, rdata);
        checkOutput("disp DSR acked", rdata, 16'h8000);
        injAck = 1'b1;
        applyStimulus(16'hFE06, 1'b1, 16'h0044, rdata);
        checkOutput("disp2 valid count", 16'(dvCount), 16'd1);
        checkOutput("disp2 dispChar", {8'h00, dispChar}, 16'h0044);
        applyStimulus(16'hFE04, 1'b0, 16'h0000, rdata);
        checkOutput("disp race DSR", rdata, 16'h0000);

        // Stability: loads during WAIT are ignored
        stress = 1'b1;
        applyStimulus(16'h0030, 1'b1, 16'h7777, rdata);
        checkOutput("stab MARReg", MARReg, 16'h0030);
        checkOutput("stab mdrOut", mdrOut, 16'h7777);
        checkOutput("stab R cycle", 16'(rCycle), 16'(LAT + 1));
        checkOutput("stab mem[0030]", mem[16'h0030], 16'h7777);
        checkOutput("stab mem[1234]", mem[16'h1234], 16'h0000);

        // I/O writes never reach the array
        applyStimulus(16'hFE00, 1'b1, 16'hFFFF, rdata);
        checkOutput("io KBSR wr memWE", 16'(weCount), 16'd0);
        applyStimulus(16'hFE00, 1'b0, 16'h0000, rdata);
        checkOutput("io KBSR unchanged", rdata, 16'h0000);
        applyStimulus(16'hFFFE, 1'b1, 16'h1234, rdata);
        checkOutput("io FFFE wr memWE", 16'(weCount), 16'd0);
        checkOutput("io mem[FFFE]", mem[16'hFFFE], 16'h0000);
        applyStimulus(16'hFFFE, 1'b0, 16'h0000, rdata);
        checkOutput("io rd FFFE", rdata, 16'h0000);

        // Reset in the middle of a memory write
        weCount = 0; rCount = 0;
        ldMAR = 1'b1; Buss = 16'h0020;
        tick;
        ldMAR = 1'b0; ldMDR = 1'b1; Buss = 16'h5555;
        tick;
        ldMDR = 1'b0; Buss = 16'h0000; memEN = 1'b1; rW = 1'b1;
        tick;
        memEN = 1'b0; rW = 1'b0;
        if (memWE) weCount++;
        reset = 1'b1;
        tick;
        if (memWE) weCount++;
        checkOutput("rstmid MARReg", MARReg, 16'h0000);
        checkOutput("rstmid mdrOut", mdrOut, 16'h0000);
        checkOutput("rstmid dispChar", {8'h00, dispChar}, 16'h0000);
        checkOutput("rstmid dispValid", {15'b0, dispValid}, 16'h0000);
        checkOutput("rstmid R", {15'b0, R}, 16'h0000);
        reset = 1'b0;
        for (int c = 0; c < LAT + 4; c++) begin
            tick;
            if (memWE) weCount++;
            if (R) rCount++;
        end
        checkOutput("rstmid memWE count", 16'(weCount), 16'd0);
        checkOutput("rstmid R count", 16'(rCount), 16'd0);
        checkOutput("rstmid mem[0020]", mem[16'h0020], 16'h0000);
        applyStimulus(16'hFE04, 1'b0, 16'h0000, rdata);
        checkOutput("rstmid DSR", rdata, 16'h8000);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/lc3_mem_ctrl.md
# lc3_mem_ctrl

Memory-side access controller for the LC-3 datapath: the initiator that sits between the control FSM/bus and the word-addressed memory array. It owns the MAR and MDR registers, sequences read/write transactions with a fixed number of wait states, reports completion on the LC-3 ready signal R, and decodes the xFE00–xFFFF I/O page into the keyboard and display device registers. It drives the array's address, write data and write-enable, and consumes the array's asynchronous read data.

## Interface
Parameters:
- MEM_LATENCY, 2: wait-state cycles per access; legal range 1–15.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- Buss  in  16  datapath bus.
- ldMAR  in  1  load MAR from Buss.
- ldMDR  in  1  load MDR.
- selMDR  in  1  MDR source: 0 = Buss, 1 = read data.
- memEN  in  1  start an access.
- rW  in  1  access type: 1 = write, 0 = read.
- memOut  in  16  asynchronous read data from the memory array.
- MARReg  out  16  MAR contents; array address.
- mdrOut  out  16  MDR contents; array write data.
- memWE  out  1  array write enable.
- R  out  1  access-complete strobe.
- kbStrobe  in  1  keyboard character available.
- kbChar  in  8  keyboard character.
- dispChar  out  8  display character.
- dispValid  out  1  display write strobe.
- dispAck  in  1  display has consumed a character.

## Operation
- Reset: MARReg=0, mdrOut=0, memWE=0, R=0, KBSR[15]=0, KBDR=0, DSR[15]=1, dispChar=0, dispValid=0, FSM=IDLE.
- Address decode: MAR[15:9]==7'b1111111 is I/O space; every other address is memory space. Registers: KBSR xFE00 = {kbReady,15'b0}; KBDR xFE02 = {8'h00,kbd}; DSR xFE04 = {dispReady,15'b0}; DDR xFE06 is write-only. Other I/O addresses read x0000; writes to them are dropped.
- Read data: memOut for memory space, otherwise the decoded I/O register. Combinational from MAR.
- FSM states:
  - IDLE: memEN=1 latches rW and goes to WAIT with the counter set to MEM_LATENCY-1.
  - WAIT: the counter decrements. At 0 the FSM goes to DONE.
  - DONE: R=1 for exactly this cycle, then the FSM goes to IDLE.
- Write (rW=1) in DONE:
  - Memory space: memWE=1 for this one cycle only.
  - DDR: dispChar<=MDR[7:0], dispValid pulses for 1 cycle, DSR[15] clears.
  - KBSR/KBDR/DSR: write ignored.
- Read (rW=0) in DONE:
  - ldMDR with selMDR=1 in this cycle captures the read data.
  - If the address is KBDR, KBSR[15] clears.
- Register loads:
  - ldMAR is honored only in IDLE.
  - ldMDR with selMDR=0 is honored only in IDLE.
  - ldMDR with selMDR=1 is honored in IDLE or DONE.
  - All other loads while busy are ignored, so address and data stay stable for the whole access.
- memEN dropping mid-access does not abort. The access completes and R still pulses. memEN held high in DONE does not start a new access; the next access starts from IDLE.
- Keyboard: kbStrobe latches kbChar into KBDR and sets KBSR[15]. This overwrites an unread character. kbStrobe in the same cycle as a completing KBDR read: the new character wins and KBSR[15] stays 1.
- Display: dispAck sets DSR[15]. dispAck in the same cycle as a DDR write: the write wins and DSR[15]=0.

## Timing
- memEN sampled in IDLE at cycle 0: WAIT covers cycles 1..MEM_LATENCY, DONE is at cycle MEM_LATENCY+1, and IDLE resumes at MEM_LATENCY+2.
- Back-to-back accesses are therefore spaced MEM_LATENCY+2 cycles apart.
- memWE, R and dispValid are registered-state decodes: glitch-free, one cycle wide, never asserted outside DONE.
- A write to memory is visible in memOut from the cycle after DONE.
- reset asserted mid-access: the next edge forces IDLE and all reset values. No memWE or dispValid is issued for the aborted access.

## Test plan
- Memory write/read, MEM_LATENCY=2: load MAR=x0010 and MDR=xBEEF, memEN with rW=1 → memWE high only at cycle 3, R at cycle 3. Read of x0010 with ldMDR/selMDR=1 in DONE → mdrOut=xBEEF.
- Keyboard: kbStrobe with kbChar=x41 → read xFE00 returns x8000. Read xFE02 returns x0041 and KBSR then reads x0000. kbStrobe with x42 in the DONE cycle of the KBDR read → KBSR stays x8000 and KBDR=x0042.
- Display: write x0033 to xFE06 → dispValid 1 cycle, dispChar=x33, xFE04 reads x0000. dispAck → xFE04 reads x8000. dispAck coincident with a second DDR write → DSR stays x0000.
- Stability: ldMAR=1 with Buss=x1234 during WAIT → MARReg unchanged. memEN dropped after cycle 0 → R still pulses at MEM_LATENCY+1.
- Reset mid-write in WAIT → memWE never asserts, all outputs at reset values, DSR reads x8000.
- I/O writes to xFE00 and xFFFE → memWE stays 0 and no memory location changes. Read xFFFE → x0000.
